// File: rtl/brick_pkg.sv
// Shared grid geometry, state encoding and cell-index helpers for the brick frame arbiter.
package brick_pkg;

   localparam int GRID_W    = 16;
   localparam int GRID_H    = 12;
   localparam int COORD_W   = 4;
   localparam int GRID_BITS = GRID_W * GRID_H;
   localparam int IDX_W     = $clog2(GRID_BITS);
   localparam int ROW_W     = $clog2(GRID_H);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Flat bitmap position of cell (x,y); row-major, x fastest.
   function automatic logic [IDX_W-1:0] idx(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
      return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
   endfunction

   function automatic logic [IDX_W-1:0] row_base(input logic [ROW_W-1:0] row);
      return IDX_W'(row) * IDX_W'(GRID_W);
   endfunction

   // One extra bit so GRID_W itself is representable next to a COORD_W-wide field.
   function automatic logic in_range(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
      return ({1'b0, x} < (COORD_W+1)'(GRID_W)) && ({1'b0, y} < (COORD_W+1)'(GRID_H));
   endfunction

endpackage

// File: rtl/brick_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the loser after every grant.
module brick_rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       enable,
   output logic [1:0] grant
);

   logic rr_ptr;

   // Under contention rr_ptr names the favoured requester; a lone requester always wins.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
         end else begin
            grant = valid;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr <= 1'b0;
      end else if (grant[0]) begin
         rr_ptr <= 1'b1;
      end else if (grant[1]) begin
         rr_ptr <= 1'b0;
      end
   end

endmodule

// File: rtl/brick_frame_arbiter.sv
// Owns the 16x12 brick bitmap: arbitrates cell writes, sequences clears, commits at frame start.
// BRICK_FRAME_DOUBLE_BUFFER_EN adds a shadow grid committed to data only at frame start.
module brick_frame_arbiter
   import brick_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [COORD_W-1:0]   req0_x,
   input  logic [COORD_W-1:0]   req0_y,
   input  logic                 req0_val,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [COORD_W-1:0]   req1_x,
   input  logic [COORD_W-1:0]   req1_y,
   input  logic                 req1_val,
   input  logic                 clear_req,
   output logic                 clear_busy,
   output logic [GRID_BITS-1:0] data,
   output logic                 commit_done,
   output logic                 oob_drop
);

   state_t               state;
   state_t               state_next;
   logic [ROW_W-1:0]     clr_row;
   logic [ROW_W-1:0]     clr_row_next;
   logic                 commit_pending;
   logic                 commit_pending_next;
   logic                 arb_enable;
   logic                 clear_row_en;
   logic [1:0]           grant;
   logic                 wr_fire;
   logic [COORD_W-1:0]   wr_x;
   logic [COORD_W-1:0]   wr_y;
   logic                 wr_val;
   logic                 wr_ok;
   logic [GRID_BITS-1:0] work_grid;
   logic [GRID_BITS-1:0] grid_next;
`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
   logic                 do_commit;
   logic [GRID_BITS-1:0] shadow;
`endif

   brick_rr_arb2 u_arb (
      .clock  (clock),
      .reset  (reset),
      .valid  ({req1_valid, req0_valid}),
      .enable (arb_enable),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign clear_busy = (state == CLEAR);

   // Commit beats clear beats writes; a frame_start seen mid-clear is deferred until IDLE.
   always_comb begin
      state_next          = state;
      clr_row_next        = clr_row;
      commit_pending_next = commit_pending;
      arb_enable          = 1'b0;
      clear_row_en        = 1'b0;
`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
      do_commit           = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
            if (frame_start || commit_pending) begin
               do_commit           = 1'b1;
               commit_pending_next = 1'b0;
            end else if (clear_req) begin
               state_next   = CLEAR;
               clr_row_next = '0;
            end else begin
               arb_enable = 1'b1;
            end
`else
            if (clear_req) begin
               state_next   = CLEAR;
               clr_row_next = '0;
            end else begin
               arb_enable = 1'b1;
            end
`endif
         end
         CLEAR: begin
            clear_row_en = 1'b1;
`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
            if (frame_start) begin
               commit_pending_next = 1'b1;
            end
`endif
            if (clr_row == ROW_W'(GRID_H - 1)) begin
               state_next = IDLE;
            end else begin
               clr_row_next = clr_row + 1'b1;
            end
         end
      endcase
   end

   // Selected write; out-of-range cells still complete the handshake but touch nothing.
   always_comb begin
      wr_fire = |grant;
      wr_x    = grant[1] ? req1_x   : req0_x;
      wr_y    = grant[1] ? req1_y   : req0_y;
      wr_val  = grant[1] ? req1_val : req0_val;
      wr_ok   = in_range(wr_x, wr_y);
   end

`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
   assign work_grid = shadow;
`else
   assign work_grid = data;
`endif

   always_comb begin
      grid_next = work_grid;
      if (clear_row_en) begin
         grid_next[row_base(clr_row) +: GRID_W] = '0;
      end
      if (wr_fire && wr_ok) begin
         grid_next[idx(wr_x, wr_y)] = wr_val;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         clr_row        <= '0;
         commit_pending <= 1'b0;
         commit_done    <= 1'b0;
         oob_drop       <= 1'b0;
         data           <= '0;
`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
         shadow         <= '0;
`endif
      end else begin
         state          <= state_next;
         clr_row        <= clr_row_next;
         commit_pending <= commit_pending_next;
         oob_drop       <= wr_fire && !wr_ok;
`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
         commit_done    <= do_commit;
         shadow         <= grid_next;
         if (do_commit) begin
            data <= shadow;
         end
`else
         commit_done    <= frame_start;
         data           <= grid_next;
`endif
      end
   end

endmodule

// File: tb/tb_brick_frame_arbiter.sv
// Self-checking bench for brick_frame_arbiter: vector table, directed corner cases, random traffic vs model.
module tb_brick_frame_arbiter;
   import brick_pkg::*;

`ifdef BRICK_FRAME_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 frame_start;
   logic                 req0_valid, req1_valid;
   logic                 req0_ready, req1_ready;
   logic [COORD_W-1:0]   req0_x, req0_y, req1_x, req1_y;
   logic                 req0_val, req1_val;
   logic                 clear_req;
   logic                 clear_busy;
   logic [GRID_BITS-1:0] data;
   logic                 commit_done;
   logic                 oob_drop;

   brick_frame_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .frame_start (frame_start),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_x      (req0_x),
      .req0_y      (req0_y),
      .req0_val    (req0_val),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_x      (req1_x),
      .req1_y      (req1_y),
      .req1_val    (req1_val),
      .clear_req   (clear_req),
      .clear_busy  (clear_busy),
      .data        (data),
      .commit_done (commit_done),
      .oob_drop    (oob_drop)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the grids as flat bit vectors, the clear as a count of rows left to wipe.
   logic [GRID_BITS-1:0] m_shadow, m_data;
   int                   clear_left;
   bit                   m_pend;
   int                   last_winner;
   bit                   m_cd, m_oob;
   bit                   exp_r0, exp_r1;

   typedef struct {
      bit         v0, v1;
      logic [3:0] x0, y0, x1, y1;
      bit         clr;
      bit         e0, e1;
   } vec_t;

   vec_t tbl[7];

   task automatic checkBit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkVec(input string name, input logic [GRID_BITS-1:0] act,
                           input logic [GRID_BITS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset;
      m_shadow    = '0;
      m_data      = '0;
      clear_left  = 0;
      m_pend      = 1'b0;
      last_winner = 1;
      m_cd        = 1'b0;
      m_oob       = 1'b0;
   endtask

   task automatic modelPre;
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (clear_left == 0 && !(DB && (frame_start || m_pend)) && !clear_req) begin
         if (req0_valid && req1_valid) begin
            if (last_winner == 1) exp_r0 = 1'b1;
            else                  exp_r1 = 1'b1;
         end else begin
            exp_r0 = req0_valid;
            exp_r1 = req1_valid;
         end
      end
   endtask

   task automatic setCell(input int pos, input bit v);
      if (DB) m_shadow[pos] = v;
      else    m_data[pos]   = v;
   endtask

   task automatic modelPost;
      bit commit_now, go_clear, fired, gval;
      int gx, gy, row;
      commit_now = DB && clear_left == 0 && (frame_start || m_pend);
      go_clear   = clear_left == 0 && !commit_now && clear_req;
      fired      = exp_r0 || exp_r1;
      gx         = exp_r1 ? int'(req1_x) : int'(req0_x);
      gy         = exp_r1 ? int'(req1_y) : int'(req0_y);
      gval       = exp_r1 ? req1_val : req0_val;
      m_cd       = DB ? commit_now : frame_start;
      m_oob      = fired && (gx >= GRID_W || gy >= GRID_H);
      if (clear_left > 0) begin
         row = GRID_H - clear_left;
         for (int c = 0; c < GRID_W; c++) setCell(row * GRID_W + c, 1'b0);
         if (DB && frame_start) m_pend = 1'b1;
         clear_left--;
      end else if (commit_now) begin
         m_data = m_shadow;
         m_pend = 1'b0;
      end else if (go_clear) begin
         clear_left = GRID_H;
      end
      if (fired) begin
         last_winner = exp_r1 ? 1 : 0;
         if (gx < GRID_W && gy < GRID_H) setCell(gy * GRID_W + gx, gval);
      end
   endtask

   // Entered just after a falling edge with inputs driven; returns at the next falling edge.
   task automatic applyStimulus;
      #1;
      modelPre;
      checkBit("req0_ready", req0_ready, exp_r0);
      checkBit("req1_ready", req1_ready, exp_r1);
      modelPost;
      @(posedge clock);
      #1;
      checkVec("data", data, m_data);
      checkBit("commit_done", commit_done, m_cd);
      checkBit("oob_drop", oob_drop, m_oob);
      checkBit("clear_busy", clear_busy, clear_left > 0);
      @(negedge clock);
   endtask

   task automatic idleInputs;
      frame_start = 1'b0;
      clear_req   = 1'b0;
      req0_valid  = 1'b0;
      req1_valid  = 1'b0;
      req0_x = '0; req0_y = '0; req0_val = 1'b0;
      req1_x = '0; req1_y = '0; req1_val = 1'b0;
   endtask

   task automatic doReset;
      idleInputs;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      modelReset;
      checkVec("reset_data", data, '0);
      checkBit("reset_commit_done", commit_done, 1'b0);
      checkBit("reset_oob_drop", oob_drop, 1'b0);
      checkBit("reset_clear_busy", clear_busy, 1'b0);
      @(negedge clock);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus;
   endtask

   task automatic pulseFrame;
      frame_start = 1'b1;
      applyStimulus;
      frame_start = 1'b0;
   endtask

   // Holds one request until the model says it transferred, with a cycle budget.
   task automatic sendReq(input int which, input int x, input int y, input bit v);
      bit done;
      done = 1'b0;
      if (which == 0) begin
         req0_valid = 1'b1; req0_x = 4'(x); req0_y = 4'(y); req0_val = v;
      end else begin
         req1_valid = 1'b1; req1_x = 4'(x); req1_y = 4'(y); req1_val = v;
      end
      for (int i = 0; i < 32 && !done; i++) begin
         applyStimulus;
         done = (which == 0) ? exp_r0 : exp_r1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL send_timeout: requester %0d not granted within 32 cycles", which);
      end
      if (which == 0) req0_valid = 1'b0;
      else            req1_valid = 1'b0;
   endtask

   initial begin
      int busy_cnt;
      logic [GRID_BITS-1:0] saved;

      idleInputs;
      reset = 1'b1;
      @(negedge clock);
      doReset;

      // Vector table: round-robin under contention, then clear blocking both requesters.
      tbl[0] = '{v0:1, v1:0, x0:0, y0:0, x1:0, y1:0, clr:0, e0:1, e1:0};
      tbl[1] = '{v0:1, v1:1, x0:1, y0:0, x1:2, y1:0, clr:0, e0:0, e1:1};
      tbl[2] = '{v0:1, v1:1, x0:1, y0:0, x1:3, y1:0, clr:0, e0:1, e1:0};
      tbl[3] = '{v0:1, v1:1, x0:4, y0:0, x1:3, y1:0, clr:0, e0:0, e1:1};
      tbl[4] = '{v0:1, v1:1, x0:4, y0:0, x1:5, y1:0, clr:0, e0:1, e1:0};
      tbl[5] = '{v0:1, v1:1, x0:6, y0:0, x1:5, y1:0, clr:1, e0:0, e1:0};
      tbl[6] = '{v0:1, v1:1, x0:6, y0:0, x1:5, y1:0, clr:0, e0:0, e1:0};
      for (int i = 0; i < 7; i++) begin
         req0_valid = tbl[i].v0; req0_x = tbl[i].x0; req0_y = tbl[i].y0; req0_val = 1'b1;
         req1_valid = tbl[i].v1; req1_x = tbl[i].x1; req1_y = tbl[i].y1; req1_val = 1'b1;
         clear_req  = tbl[i].clr;
         #1;
         checkBit($sformatf("tbl%0d_r0", i), req0_ready, tbl[i].e0);
         checkBit($sformatf("tbl%0d_r1", i), req1_ready, tbl[i].e1);
         applyStimulus;
      end
      idleInputs;
      idleCycles(13);

      // Single write then commit.
      doReset;
      sendReq(0, 3, 2, 1'b1);
      checkBit("write_visible_bit35", data[35], DB ? 1'b0 : 1'b1);
      pulseFrame;
      checkBit("commit_bit35", data[35], 1'b1);
      checkBit("commit_done_pulse", commit_done, 1'b1);
      idleCycles(1);

      // Out-of-range write completes but changes nothing.
      saved = data;
      sendReq(1, 5, 12, 1'b1);
      checkBit("oob_pulse", oob_drop, 1'b1);
      idleCycles(1);
      pulseFrame;
      checkVec("oob_data_unchanged", data, saved);

      // frame_start colliding with a pending request.
      req0_valid = 1'b1; req0_x = 4'd7; req0_y = 4'd1; req0_val = 1'b1;
      frame_start = 1'b1;
      #1;
      checkBit("collide_ready", req0_ready, DB ? 1'b0 : 1'b1);
      applyStimulus;
      frame_start = 1'b0;
      if (exp_r0) req0_valid = 1'b0;
      #1;
      checkBit("collide_next_ready", req0_ready, DB ? 1'b1 : 1'b0);
      applyStimulus;
      req0_valid = 1'b0;
      checkBit("collide_not_shown", data[23], DB ? 1'b0 : 1'b1);
      pulseFrame;
      checkBit("collide_commit", data[23], 1'b1);

      // Fill the grid, then clear with a frame_start arriving on CLEAR cycle 5.
      for (int y = 0; y < GRID_H; y++)
         for (int x = 0; x < GRID_W; x++)
            sendReq(x % 2, x, y, 1'b1);
      pulseFrame;
      checkVec("full_grid", data, '1);
      clear_req = 1'b1;
      applyStimulus;
      clear_req = 1'b0;
      busy_cnt = 0;
      for (int k = 1; k <= 14; k++) begin
         if (clear_busy) busy_cnt++;
         frame_start = (k == 5);
         applyStimulus;
      end
      frame_start = 1'b0;
      checkInt("clear_busy_cycles", busy_cnt, GRID_H);
      checkVec("clear_data", data, '0);

      // Reset on CLEAR cycle 6, with a deferred commit already pending.
      sendReq(1, 2, 2, 1'b1);
      clear_req = 1'b1;
      applyStimulus;
      clear_req = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         frame_start = (k == 3);
         applyStimulus;
      end
      doReset;
      idleCycles(1);
      sendReq(0, 9, 4, 1'b1);
      checkBit("post_reset_write", data[73], DB ? 1'b0 : 1'b1);
      idleCycles(2);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         if (!req0_valid && $urandom_range(1, 0) == 1) begin
            req0_valid = 1'b1;
            req0_x   = 4'($urandom_range(15, 0));
            req0_y   = 4'($urandom_range(13, 0));
            req0_val = 1'($urandom_range(1, 0));
         end
         if (!req1_valid && $urandom_range(1, 0) == 1) begin
            req1_valid = 1'b1;
            req1_x   = 4'($urandom_range(15, 0));
            req1_y   = 4'($urandom_range(13, 0));
            req1_val = 1'($urandom_range(1, 0));
         end
         frame_start = ($urandom_range(15, 0) == 0);
         clear_req   = ($urandom_range(39, 0) == 0);
         applyStimulus;
         if (exp_r0) req0_valid = 1'b0;
         if (exp_r1) req1_valid = 1'b0;
      end
      idleInputs;
      idleCycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
